// File: rtl/twisted_ring_counter.sv
// Parametrised Johnson / one-hot ring counter with direction, enable, checked
// parallel load, illegal-state self-correction, decoded phase and wrap/fault pulses.
module twisted_ring_counter #(
  parameter int WIDTH = 4,
  parameter int MODE  = 0,
  parameter int PW    = $clog2(2*WIDTH)
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             Enable,
  input  logic             Dir,
  input  logic             Load,
  input  logic [WIDTH-1:0] Load_value,
  output logic [WIDTH-1:0] Count_out,
  output logic [PW-1:0]    Phase,
  output logic             Wrap,
  output logic             Fault
);

  localparam int N = (MODE == 1) ? WIDTH : 2*WIDTH;
  localparam logic [WIDTH-1:0] R0 = (MODE == 1) ? WIDTH'(1) : '0;

  logic [WIDTH-1:0] count_q, count_d;
  logic             wrap_q, wrap_d;
  logic             fault_q, fault_d;
  logic [PW-1:0]    phase_cur;
  logic             legal_cur, load_legal;
  logic [WIDTH-1:0] up_next, down_next;

  // Johnson patterns are exactly those with at most one 0/1 boundary between neighbours.
  function automatic logic is_legal(input logic [WIDTH-1:0] v);
    int ones;
    int edges;
    ones  = 0;
    edges = 0;
    for (int i = 0; i < WIDTH; i++) ones += int'(v[i]);
    for (int i = 0; i < WIDTH-1; i++) edges += int'(v[i] ^ v[i+1]);
    if (MODE == 1) return (ones == 1);
    return (edges <= 1);
  endfunction

  function automatic logic [PW-1:0] phase_of(input logic [WIDTH-1:0] v);
    int ones;
    int idx;
    ones = 0;
    idx  = 0;
    for (int i = 0; i < WIDTH; i++) begin
      if (v[i]) begin
        ones += 1;
        idx  = i;
      end
    end
    if (!is_legal(v)) return '0;
    if (MODE == 1) return PW'(idx);
    if (v[0]) return PW'(ones);
    if (ones == 0) return '0;
    return PW'(2*WIDTH - ones);
  endfunction

  always_comb begin
    phase_cur  = phase_of(count_q);
    legal_cur  = is_legal(count_q);
    load_legal = is_legal(Load_value);
    if (MODE == 1) begin
      up_next   = {count_q[WIDTH-2:0], count_q[WIDTH-1]};
      down_next = {count_q[0], count_q[WIDTH-1:1]};
    end else begin
      up_next   = {count_q[WIDTH-2:0], ~count_q[WIDTH-1]};
      down_next = {~count_q[0], count_q[WIDTH-1:1]};
    end
  end

  // Load beats correction, correction beats stepping; wrap only on a real step.
  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    fault_d = 1'b0;
    if (Load) begin
      if (load_legal) begin
        count_d = Load_value;
      end else begin
        count_d = R0;
        fault_d = 1'b1;
      end
    end else if (!legal_cur) begin
      count_d = R0;
      fault_d = 1'b1;
    end else if (Enable) begin
      if (!Dir) begin
        count_d = up_next;
        wrap_d  = (phase_cur == PW'(N-1));
      end else begin
        count_d = down_next;
        wrap_d  = (phase_cur == '0);
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      count_q <= R0;
      wrap_q  <= 1'b0;
      fault_q <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
      fault_q <= fault_d;
    end
  end

  assign Count_out = count_q;
  assign Phase     = phase_cur;
  assign Wrap      = wrap_q;
  assign Fault     = fault_q;

endmodule

// File: tb/tb_twisted_ring_counter.sv
// Bench for twisted_ring_counter: a 4-bit Johnson and a 5-bit ring instance checked
// every cycle against a phase-index model, plus directed literal sequences.
module tb_twisted_ring_counter;

  localparam int WA = 4;
  localparam int WB = 5;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic en[2];
  logic dir[2];
  logic ld[2];
  logic [31:0] ldv[2];

  logic [WA-1:0] countA;
  logic [2:0]    phaseA;
  logic          wrapA, faultA;
  logic [WB-1:0] countB;
  logic [3:0]    phaseB;
  logic          wrapB, faultB;

  int total = 0;
  int bad = 0;

  int widthOf[2] = '{WA, WB};
  int modeOf[2]  = '{0, 1};
  int mP[2]      = '{0, 0};
  bit mIll[2]    = '{1'b0, 1'b0};
  logic [31:0] mIllVal[2];
  bit mWrap[2]   = '{1'b0, 1'b0};
  bit mFault[2]  = '{1'b0, 1'b0};

  twisted_ring_counter #(.WIDTH(WA), .MODE(0)) dutA (
    .Clock(clock), .Reset(reset), .Enable(en[0]), .Dir(dir[0]), .Load(ld[0]),
    .Load_value(ldv[0][WA-1:0]), .Count_out(countA), .Phase(phaseA),
    .Wrap(wrapA), .Fault(faultA)
  );

  twisted_ring_counter #(.WIDTH(WB), .MODE(1)) dutB (
    .Clock(clock), .Reset(reset), .Enable(en[1]), .Dir(dir[1]), .Load(ld[1]),
    .Load_value(ldv[1][WB-1:0]), .Count_out(countB), .Phase(phaseB),
    .Wrap(wrapB), .Fault(faultB)
  );

  always #5 clock = ~clock;

  function automatic logic [31:0] maskOf(input int w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

  // State at phase p: ring is a single bit; Johnson fills ones from the bottom, then drains them.
  function automatic logic [31:0] patternOf(input int w, input int m, input int p);
    if (m == 1) return 32'd1 << p;
    if (p <= w) return maskOf(p);
    return maskOf(w) & ~maskOf(p - w);
  endfunction

  function automatic int numStates(input int i);
    return (modeOf[i] == 1) ? widthOf[i] : 2*widthOf[i];
  endfunction

  function automatic int phaseOfValue(input int i, input logic [31:0] v);
    for (int k = 0; k < numStates(i); k++)
      if (patternOf(widthOf[i], modeOf[i], k) == (v & maskOf(widthOf[i]))) return k;
    return -1;
  endfunction

  function automatic logic [31:0] expCount(input int i);
    if (mIll[i]) return mIllVal[i];
    return patternOf(widthOf[i], modeOf[i], mP[i]);
  endfunction

  function automatic logic [31:0] expPhase(input int i);
    if (mIll[i]) return 32'd0;
    return 32'(mP[i]);
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
    total++;
    if (actual !== required) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, actual, required, $time);
    end
  endtask

  task automatic applyStimulus(input int i, input logic e, input logic d, input logic l, input logic [31:0] v);
    en[i]  = e;
    dir[i] = d;
    ld[i]  = l;
    ldv[i] = v;
  endtask

  // Reference model: tracks only the phase index (or a flagged illegal value).
  always @(posedge clock or posedge reset) begin
    for (int i = 0; i < 2; i++) begin
      int n;
      int k;
      n = numStates(i);
      if (reset) begin
        mP[i] = 0; mIll[i] = 1'b0; mWrap[i] = 1'b0; mFault[i] = 1'b0;
      end else begin
        mWrap[i] = 1'b0;
        mFault[i] = 1'b0;
        if (ld[i]) begin
          k = phaseOfValue(i, ldv[i]);
          mIll[i] = 1'b0;
          if (k >= 0) mP[i] = k;
          else begin mP[i] = 0; mFault[i] = 1'b1; end
        end else if (mIll[i]) begin
          mP[i] = 0; mIll[i] = 1'b0; mFault[i] = 1'b1;
        end else if (en[i]) begin
          if (!dir[i]) begin
            mWrap[i] = (mP[i] == n-1);
            mP[i] = (mP[i] + 1) % n;
          end else begin
            mWrap[i] = (mP[i] == 0);
            mP[i] = (mP[i] + n - 1) % n;
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    checkOutput("A.count", 32'(countA), expCount(0));
    checkOutput("A.phase", 32'(phaseA), expPhase(0));
    checkOutput("A.wrap",  32'(wrapA),  32'(mWrap[0]));
    checkOutput("A.fault", 32'(faultA), 32'(mFault[0]));
    checkOutput("B.count", 32'(countB), expCount(1));
    checkOutput("B.phase", 32'(phaseB), expPhase(1));
    checkOutput("B.wrap",  32'(wrapB),  32'(mWrap[1]));
    checkOutput("B.fault", 32'(faultB), 32'(mFault[1]));
  end

  task automatic forceIllegal(input int i, input logic [31:0] v);
    int k;
    if (i == 0) force dutA.count_q = v[WA-1:0];
    else        force dutB.count_q = v[WB-1:0];
    k = phaseOfValue(i, v);
    if (k < 0) begin
      mIll[i] = 1'b1;
      mIllVal[i] = v & maskOf(widthOf[i]);
    end else begin
      mIll[i] = 1'b0;
      mP[i] = k;
    end
    #1;
    if (i == 0) release dutA.count_q;
    else        release dutB.count_q;
  endtask

  initial begin
    logic [3:0] upSeq[8];
    logic [3:0] downSeq[5];
    logic [31:0] v;
    int sel;
    upSeq   = '{4'b0000, 4'b0001, 4'b0011, 4'b0111, 4'b1111, 4'b1110, 4'b1100, 4'b1000};
    downSeq = '{4'b1000, 4'b1100, 4'b1110, 4'b1100, 4'b1000};
    for (int i = 0; i < 2; i++) applyStimulus(i, 1'b0, 1'b0, 1'b0, 32'd0);
    #1 reset = 1'b1;
    #47;
    checkOutput("rst.countA", 32'(countA), 32'h0);
    checkOutput("rst.phaseA", 32'(phaseA), 32'h0);
    checkOutput("rst.wrapA",  32'(wrapA),  32'h0);
    checkOutput("rst.faultA", 32'(faultA), 32'h0);
    checkOutput("rst.countB", 32'(countB), 32'h1);
    checkOutput("rst.phaseB", 32'(phaseB), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'd0);
    applyStimulus(1, 1'b1, 1'b0, 1'b0, 32'd0);
    for (int k = 1; k <= 8; k++) begin
      @(negedge clock);
      checkOutput("up.count", 32'(countA), 32'(upSeq[k % 8]));
      checkOutput("up.phase", 32'(phaseA), 32'(k % 8));
      checkOutput("up.wrap",  32'(wrapA),  32'(k == 8));
      checkOutput("ring.count", 32'(countB), 32'd1 << (k % 5));
      checkOutput("ring.phase", 32'(phaseB), 32'(k % 5));
      checkOutput("ring.wrap",  32'(wrapB),  32'(k == 5));
    end
    applyStimulus(1, 1'b0, 1'b0, 1'b0, 32'd0);
    applyStimulus(0, 1'b1, 1'b1, 1'b0, 32'd0);
    for (int k = 0; k < 5; k++) begin
      if (k == 3) dir[0] = 1'b0;
      @(negedge clock);
      checkOutput("down.count", 32'(countA), 32'(downSeq[k]));
      checkOutput("down.wrap",  32'(wrapA),  32'(k == 0));
    end
    applyStimulus(0, 1'b1, 1'b0, 1'b1, 32'h7);
    @(negedge clock);
    checkOutput("load.count", 32'(countA), 32'h7);
    checkOutput("load.phase", 32'(phaseA), 32'd3);
    checkOutput("load.fault", 32'(faultA), 32'd0);
    applyStimulus(0, 1'b0, 1'b0, 1'b1, 32'h5);
    @(negedge clock);
    checkOutput("badload.count", 32'(countA), 32'h0);
    checkOutput("badload.fault", 32'(faultA), 32'd1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0, 32'h0);
    @(negedge clock);
    checkOutput("badload.faultpulse", 32'(faultA), 32'd0);
    forceIllegal(0, 32'hA);
    forceIllegal(1, 32'h6);
    checkOutput("seu.held", 32'(countA), 32'hA);
    checkOutput("seu.phaseA", 32'(phaseA), 32'd0);
    checkOutput("seu.phaseB", 32'(phaseB), 32'd0);
    @(negedge clock);
    checkOutput("seu.fixA", 32'(countA), 32'h0);
    checkOutput("seu.faultA", 32'(faultA), 32'd1);
    checkOutput("seu.fixB", 32'(countB), 32'h1);
    checkOutput("seu.faultB", 32'(faultB), 32'd1);
    @(negedge clock);
    checkOutput("seu.faultpulse", 32'(faultA), 32'd0);
    applyStimulus(0, 1'b1, 1'b0, 1'b0, 32'd0);
    repeat (5) @(negedge clock);
    checkOutput("arst.pre", 32'(countA), 32'hE);
    #2 reset = 1'b1;
    #1;
    checkOutput("arst.count", 32'(countA), 32'h0);
    checkOutput("arst.phase", 32'(phaseA), 32'h0);
    checkOutput("arst.wrap",  32'(wrapA),  32'h0);
    checkOutput("arst.fault", 32'(faultA), 32'h0);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    checkOutput("arst.resume", 32'(countA), 32'h1);

    for (int c = 0; c < 3000; c++) begin
      @(negedge clock);
      for (int i = 0; i < 2; i++) begin
        if ($urandom_range(0, 1) == 0)
          v = patternOf(widthOf[i], modeOf[i], $urandom_range(0, numStates(i) - 1));
        else
          v = $urandom & maskOf(widthOf[i]);
        applyStimulus(i, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)),
                      $urandom_range(0, 7) == 0, v);
      end
      if (reset) begin
        reset = 1'b0;
      end else if ($urandom_range(0, 63) == 0) begin
        sel = $urandom_range(0, 1);
        forceIllegal(sel, $urandom);
      end else if ($urandom_range(0, 199) == 0) begin
        #2 reset = 1'b1;
      end
    end
    @(negedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
